// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared loader state encodings and word-size constant
package core_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_START,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int CORE_LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/core_loader_asm.sv
// rtl/core_loader_asm.sv - little-endian byte-to-word assembler
module core_loader_asm
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_LANE = 2'(CORE_LOADER_WORD_BYTES - 1);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] sr_q, sr_d;

  // Bytes shift in from the top, so byte 0 ends up in the low lane.
  always_comb begin
    lane_d = lane_q;
    sr_d   = sr_q;
    if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      sr_d   = {byte_data_i, sr_q[23:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      sr_q   <= '0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
    end
  end

  assign word_valid_o = byte_valid_i && (lane_q == LAST_LANE);
  assign word_o       = {byte_data_i, sr_q};

endmodule

// File: rtl/core_loader.sv
// rtl/core_loader.sv - boot loader streaming an image into imem; CORE_LOADER_CSUM_EN adds checksum check
module core_loader
  import core_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef CORE_LOADER_CSUM_EN
  localparam loader_state_t S_AFTER_DATA = S_CSUM;
`else
  localparam loader_state_t S_AFTER_DATA = S_START;
`endif

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d, idx_q, idx_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              asm_valid, word_valid;
  logic [31:0]       word;
`ifdef CORE_LOADER_CSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  assign rx_ready  = state_q inside {S_LEN, S_DATA, S_CSUM, S_ERR};
  // Bytes drained in S_ERR never reach the assembler.
  assign asm_valid = rx_valid && (state_q inside {S_LEN, S_DATA, S_CSUM});

  core_loader_asm u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (asm_valid),
    .byte_data_i  (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q || (rx_valid && rx_ready);
`ifdef CORE_LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_LEN: if (word_valid) begin
        if (word > 32'(DEPTH)) begin
          state_d = S_ERR;
        end else begin
          n_d     = word[ADDR_W:0];
          state_d = (word == 32'd0) ? S_AFTER_DATA : S_DATA;
        end
      end
      S_DATA: if (word_valid) begin
        wen_d   = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = word;
        idx_d   = idx_q + (ADDR_W+1)'(1);
`ifdef CORE_LOADER_CSUM_EN
        sum_d   = sum_q + word;
`endif
        if (idx_q == n_q - (ADDR_W+1)'(1)) state_d = S_AFTER_DATA;
      end
`ifdef CORE_LOADER_CSUM_EN
      S_CSUM: if (word_valid) begin
        state_d = (word == sum_q) ? S_START : S_ERR;
      end
`endif
      // Hold off the start until the final word write has left.
      S_START: if (!wen_q) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN;
      n_q     <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef CORE_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
`ifdef CORE_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign imem_wen   = wen_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_start = (state_q == S_START) && !wen_q;
  assign done       = core_start || (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign busy       = busy_q && !(state_q inside {S_DONE, S_ERR});

endmodule
